// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the dynamic branch predictor: counter encodings,
// training opcodes and saturating counter arithmetic.
package branch_predictor_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned IDX_BITS_DEF = 5;
  localparam int unsigned CNT_W        = 2;

  typedef enum logic [CNT_W-1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_e;

  typedef enum logic [1:0] {
    TRAIN_NONE      = 2'd0,
    TRAIN_TAKEN     = 2'd1,
    TRAIN_NOT_TAKEN = 2'd2,
    TRAIN_INVAL     = 2'd3
  } train_op_e;

  // One training request from the ID stage towards the table write port
  typedef struct packed {
    train_op_e       op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } train_req_t;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(ST)) ? c : CNT_W'(c + CNT_W'(1));
  endfunction

  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(SNT)) ? c : CNT_W'(c - CNT_W'(1));
  endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// Direct-mapped predictor table: valid/tag/target/2-bit counter per entry,
// one combinational lookup port and one synchronous read-modify-write training port.
module branch_predictor_bp_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = IDX_BITS_DEF,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] rd_pc,
  output logic        rd_hit_c,
  output logic [1:0]  rd_cnt_c,
  output logic [31:0] rd_target_c,
  input  train_op_e   wr_op,
  input  logic [31:2] wr_pc,
  input  logic [31:0] wr_target
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = XLEN - IDX_BITS - 2;

  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic [IDX_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]    rd_tag;
  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]    wr_tag;
  logic                wr_hit;

  assign rd_idx = rd_pc[IDX_BITS+1:2];
  assign rd_tag = rd_pc[31:IDX_BITS+2];
  assign wr_idx = wr_pc[IDX_BITS+1:2];
  assign wr_tag = wr_pc[31:IDX_BITS+2];

  assign rd_hit_c    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_cnt_c    = cnt_q[rd_idx];
  assign rd_target_c = target_q[rd_idx];

  // Hit is re-evaluated against the current contents at training time, so an
  // entry retrained since the prediction was made is still updated correctly.
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[IDX_BITS'(i)]  <= 1'b0;
        tag_q[IDX_BITS'(i)]    <= '0;
        target_q[IDX_BITS'(i)] <= '0;
        cnt_q[IDX_BITS'(i)]    <= CNT_INIT;
      end
    end else begin
      case (wr_op)
        TRAIN_TAKEN: begin
          valid_q[wr_idx]  <= 1'b1;
          tag_q[wr_idx]    <= wr_tag;
          target_q[wr_idx] <= wr_target;
          cnt_q[wr_idx]    <= wr_hit ? cnt_inc(cnt_q[wr_idx]) : CNT_W'(WT);
        end
        TRAIN_NOT_TAKEN: begin
          if (wr_hit) cnt_q[wr_idx] <= cnt_dec(cnt_q[wr_idx]);
        end
        TRAIN_INVAL: begin
          if (wr_hit) valid_q[wr_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: IF lookup, IF/ID prediction register, ID-stage
// misprediction detection with redirect PC, and table training.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = IDX_BITS_DEF,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        flush,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        id_is_branch,
  input  logic        id_branch_judge,
  input  logic [31:0] id_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  logic             lk_hit;
  logic [CNT_W-1:0] lk_cnt;
  logic [XLEN-1:0]  lk_target;

  logic [XLEN-1:0]  pc_q;
  logic             taken_q;
  logic [XLEN-1:0]  target_q;
  logic             vld_q;

  train_req_t       train;

  branch_predictor_bp_table #(
    .IDX_BITS (IDX_BITS),
    .CNT_INIT (CNT_INIT)
  ) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_pc       (if_pc[31:2]),
    .rd_hit_c    (lk_hit),
    .rd_cnt_c    (lk_cnt),
    .rd_target_c (lk_target),
    .wr_op       (train.op),
    .wr_pc       (train.pc[31:2]),
    .wr_target   (train.target)
  );

  // Zero-latency lookup for the PC currently being fetched
  assign pred_taken  = lk_hit && lk_cnt[1];
  assign pred_target = pred_taken ? lk_target : if_pc + 32'd4;

  // IF/ID prediction register; flush wins over if_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      vld_q    <= 1'b0;
    end else if (!stall) begin
      pc_q     <= if_pc;
      taken_q  <= pred_taken;
      target_q <= pred_target;
      vld_q    <= if_valid && !flush;
    end
  end

  // Resolve against the ID comparator and choose the training action
  always_comb begin
    mispredict   = 1'b0;
    redirect_pc  = pc_q + 32'd4;
    train.op     = TRAIN_NONE;
    train.pc     = pc_q;
    train.target = id_target;
    if (vld_q) begin
      if (id_is_branch && id_branch_judge) begin
        mispredict  = !taken_q || (target_q != id_target);
        redirect_pc = id_target;
        train.op    = TRAIN_TAKEN;
      end else if (id_is_branch) begin
        mispredict  = taken_q;
        train.op    = TRAIN_NOT_TAKEN;
      end else begin
        mispredict  = taken_q;
        train.op    = TRAIN_INVAL;
      end
      if (stall) train.op = TRAIN_NONE;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic, all compared against a table-level behavioural model.
module tb_branch_predictor;

  localparam int unsigned IDX = 5;
  localparam int unsigned ENT = 1 << IDX;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_valid, stall, flush;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_is_branch, id_branch_judge;
  logic [31:0] id_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int checks = 0;
  int fails  = 0;

  // behavioural model state
  bit          m_v   [ENT];
  logic [31:0] m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_cnt [ENT];
  logic [31:0] m_pc, m_target;
  logic        m_taken, m_vld;

  // expectations for the current cycle
  logic        e_taken, e_mis;
  logic [31:0] e_target, e_redir;

  // snapshots taken by pair()
  logic        lk_o_t, lk_e_t, rs_o_m, rs_e_m;
  logic [31:0] lk_o_g, lk_e_g, rs_o_r, rs_e_r;

  branch_predictor #(.IDX_BITS(IDX), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_valid(if_valid),
    .stall(stall), .flush(flush), .pred_taken(pred_taken),
    .pred_target(pred_target), .id_is_branch(id_is_branch),
    .id_branch_judge(id_branch_judge), .id_target(id_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % ENT;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
    m_pc = '0; m_target = '0; m_taken = 0; m_vld = 0;
  endtask

  task automatic model_eval();
    e_taken  = m_hit(if_pc) && (m_cnt[idx_of(if_pc)] >= 2);
    e_target = e_taken ? m_tgt[idx_of(if_pc)] : if_pc + 32'd4;
    e_mis    = 1'b0;
    e_redir  = m_pc + 32'd4;
    if (m_vld) begin
      if (id_is_branch && id_branch_judge) begin
        e_mis   = !m_taken || (m_target != id_target);
        e_redir = id_target;
      end else begin
        e_mis = m_taken;
      end
    end
  endtask

  task automatic model_update();
    int unsigned i;
    if (stall) return;
    if (m_vld) begin
      i = idx_of(m_pc);
      if (id_is_branch && id_branch_judge) begin
        m_cnt[i] = m_hit(m_pc) ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : 2;
        m_v[i] = 1; m_tag[i] = tag_of(m_pc); m_tgt[i] = id_target;
      end else if (id_is_branch) begin
        if (m_hit(m_pc)) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end else if (m_hit(m_pc)) begin
        m_v[i] = 0;
      end
    end
    m_pc = if_pc; m_taken = e_taken; m_target = e_target;
    m_vld = if_valid && !flush;
  endtask

  task automatic cyc(input logic [31:0] pc, input logic v, st, fl, br, jd,
                     input logic [31:0] tg);
    if_pc = pc; if_valid = v; stall = st; flush = fl;
    id_is_branch = br; id_branch_judge = jd; id_target = tg;
    #1;
    model_eval();
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  // fetch pc, then resolve it in the following cycle; snapshots both
  task automatic pair(input logic [31:0] pc, input logic br, jd, input logic [31:0] tg);
    cyc(pc, 1, 0, 0, 0, 0, 0);
    lk_o_t = pred_taken; lk_o_g = pred_target; lk_e_t = e_taken; lk_e_g = e_target;
    adv();
    cyc(pc + 32'd4, 0, 0, 0, br, jd, tg);
    rs_o_m = mispredict; rs_o_r = redirect_pc; rs_e_m = e_mis; rs_e_r = e_redir;
    adv();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    cyc(32'h100, 1, 0, 0, 1, 1, 32'h80);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104 || mispredict !== 1'b0) begin
      fails++;
      $display("FAIL reset: got taken=%0b target=%h mis=%0b, want 0/00000104/0",
               pred_taken, pred_target, mispredict);
    end
    adv(); adv();
    rst_n = 1'b1;
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104 || mispredict !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: got taken=%0b target=%h mis=%0b, want 0/00000104/0",
               pred_taken, pred_target, mispredict);
    end
    adv();
  endtask

  task automatic test_cold_taken();
    cyc(32'h100, 1, 0, 0, 0, 0, 0);
    adv();
    cyc(32'h104, 1, 0, 1, 1, 1, 32'h80);
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80 || e_mis !== 1'b1) begin
      fails++;
      $display("FAIL cold_mis: got mis=%0b redir=%h, want 1/00000080", mispredict, redirect_pc);
    end
    adv();
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      fails++;
      $display("FAIL cold_refetch: got %0b/%h, want 1/00000080", pred_taken, pred_target);
    end
    adv();
  endtask

  task automatic test_not_taken();
    logic exp_m [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      pair(32'h100, 1, (k == 3), 32'h80);
      checks++;
      if (rs_o_m !== rs_e_m || rs_o_m !== exp_m[k] || (rs_e_m && rs_o_r !== rs_e_r)) begin
        fails++;
        $display("FAIL not_taken[%0d]: got mis=%0b redir=%h, want mis=%0b redir=%h",
                 k, rs_o_m, rs_o_r, rs_e_m, rs_e_r);
      end
    end
    // 2->1->0->0 (clamp) then taken -> 1: still predicts not-taken
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104 || e_taken !== 1'b0) begin
      fails++;
      $display("FAIL nt_clamp: got %0b/%h, want 0/00000104", pred_taken, pred_target);
    end
    adv();
  endtask

  task automatic test_loop();
    for (int i = 0; i < 6; i++) begin
      pair(32'h140, 1, (i < 5), 32'h120);
      checks++;
      if (lk_o_t !== lk_e_t || lk_o_g !== lk_e_g || rs_o_m !== rs_e_m ||
          rs_o_m !== (i == 0 || i == 5) || (rs_e_m && rs_o_r !== rs_e_r)) begin
        fails++;
        $display("FAIL loop[%0d]: got pred=%0b/%h mis=%0b redir=%h, want pred=%0b/%h mis=%0b redir=%h",
                 i, lk_o_t, lk_o_g, rs_o_m, rs_o_r, lk_e_t, lk_e_g, rs_e_m, rs_e_r);
      end
    end
    cyc(32'h140, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h120) begin
      fails++;
      $display("FAIL loop_exit_pred: got %0b/%h, want 1/00000120", pred_taken, pred_target);
    end
    adv();
  endtask

  task automatic test_alias();
    pair(32'h100, 1, 1, 32'h80);
    pair(32'h180, 0, 0, 0);
    checks++;
    if (lk_o_t !== 1'b0 || rs_o_m !== 1'b0 || lk_e_t !== 1'b0) begin
      fails++;
      $display("FAIL alias_tagdiff: got pred=%0b mis=%0b, want 0/0", lk_o_t, rs_o_m);
    end
    pair(32'h100, 0, 0, 0);
    checks++;
    if (lk_o_t !== 1'b1 || rs_o_m !== 1'b1 || rs_o_r !== 32'h104) begin
      fails++;
      $display("FAIL alias_hit: got pred=%0b mis=%0b redir=%h, want 1/1/00000104",
               lk_o_t, rs_o_m, rs_o_r);
    end
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      fails++;
      $display("FAIL alias_inval: got %0b/%h, want 0/00000104", pred_taken, pred_target);
    end
    adv();
  endtask

  task automatic test_stall_flush();
    cyc(32'h200, 1, 0, 0, 0, 0, 0);
    adv();
    for (int k = 0; k < 3; k++) begin
      cyc(32'h200, 1, 1, 0, 1, 1, 32'h240);
      checks++;
      if (mispredict !== 1'b1 || redirect_pc !== 32'h240 || pred_taken !== 1'b0) begin
        fails++;
        $display("FAIL stall[%0d]: got mis=%0b redir=%h pred=%0b, want 1/00000240/0",
                 k, mispredict, redirect_pc, pred_taken);
      end
      adv();
    end
    cyc(32'h204, 1, 0, 1, 1, 1, 32'h240);
    adv();
    cyc(32'h200, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin
      fails++;
      $display("FAIL stall_release: got %0b/%h, want 1/00000240", pred_taken, pred_target);
    end
    adv();
    cyc(32'h280, 1, 0, 1, 0, 0, 0);
    adv();
    cyc(32'h284, 0, 0, 0, 1, 1, 32'h2c0);
    checks++;
    if (mispredict !== 1'b0) begin
      fails++;
      $display("FAIL flush_mis: got %0b, want 0", mispredict);
    end
    adv();
    cyc(32'h280, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h284) begin
      fails++;
      $display("FAIL flush_notrain: got %0b/%h, want 0/00000284", pred_taken, pred_target);
    end
    adv();
  endtask

  task automatic test_reset_mid();
    cyc(32'h300, 1, 0, 0, 0, 0, 0);
    adv();
    cyc(32'h304, 0, 0, 0, 1, 1, 32'h340);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (mispredict !== 1'b0 || pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_out: got mis=%0b pred=%0b, want 0/0", mispredict, pred_taken);
    end
    adv();
    rst_n = 1'b1;
    cyc(32'h300, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin
      fails++;
      $display("FAIL reset_mid_discard: got %0b/%h, want 0/00000304", pred_taken, pred_target);
    end
    adv();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      cyc(32'h400, 1, 0, 0, (k > 0), 1, 32'h480);
      checks++;
      if (pred_taken !== e_taken || pred_target !== e_target || mispredict !== e_mis ||
          (e_mis && redirect_pc !== e_redir) || (k == 1 && pred_taken !== 1'b0)) begin
        fails++;
        $display("FAIL b2b[%0d]: got pred=%0b/%h mis=%0b redir=%h, want pred=%0b/%h mis=%0b redir=%h",
                 k, pred_taken, pred_target, mispredict, redirect_pc,
                 e_taken, e_target, e_mis, e_redir);
      end
      adv();
    end
    cyc(32'h404, 0, 0, 0, 1, 1, 32'h480);
    adv();
  endtask

  task automatic test_random();
    logic [31:0] pc, tg;
    for (int n = 0; n < 600; n++) begin
      pc = 32'h1000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 7)
           | (32'($urandom_range(0, 1)) << 12);
      tg = 32'h8000 + (32'($urandom_range(0, 3)) << 2);
      cyc(pc, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 9) < 1), ($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 1)), tg);
      checks++;
      if (pred_taken !== e_taken || pred_target !== e_target || mispredict !== e_mis ||
          (e_mis && redirect_pc !== e_redir)) begin
        fails++;
        $display("FAIL random[%0d] pc=%h: got pred=%0b/%h mis=%0b redir=%h, want pred=%0b/%h mis=%0b redir=%h",
                 n, pc, pred_taken, pred_target, mispredict, redirect_pc,
                 e_taken, e_target, e_mis, e_redir);
      end
      adv();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_pc = '0; if_valid = 0; stall = 0; flush = 0;
    id_is_branch = 0; id_branch_judge = 0; id_target = '0;
    @(negedge clk);
    test_reset();
    test_cold_taken();
    test_not_taken();
    test_loop();
    test_alias();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
